// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two core requesters, the arbiter and the single-port memory.
// The arbiter connects through "slave"; the environment driving requests and memory uses "master".
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          I_ifreq;
    logic [AW-1:0] I_ifaddr;
    logic          O_ifdone;
    logic [DW-1:0] O_ifdata;

    logic          I_dreq;
    logic          I_dwe;
    logic [AW-1:0] I_daddr;
    logic [DW-1:0] I_dwdata;
    logic          O_ddone;
    logic [DW-1:0] O_drdata;

    logic          O_err;
    logic          O_busy;

    logic          O_memreq;
    logic          O_memwe;
    logic [AW-1:0] O_memaddr;
    logic [DW-1:0] O_memwdata;
    logic          I_memack;
    logic [DW-1:0] I_memrdata;

    modport slave (
        input  I_ifreq, I_ifaddr,
        output O_ifdone, O_ifdata,
        input  I_dreq, I_dwe, I_daddr, I_dwdata,
        output O_ddone, O_drdata,
        output O_err, O_busy,
        output O_memreq, O_memwe, O_memaddr, O_memwdata,
        input  I_memack, I_memrdata
    );

    modport master (
        output I_ifreq, I_ifaddr,
        input  O_ifdone, O_ifdata,
        output I_dreq, I_dwe, I_daddr, I_dwdata,
        input  O_ddone, O_drdata,
        input  O_err, O_busy,
        input  O_memreq, O_memwe, O_memaddr, O_memwdata,
        output I_memack, I_memrdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store,
// with one registered transaction in flight and a watchdog that aborts unacknowledged accesses.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          I_clk,
    input  logic          I_reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        r_state,      w_state_next;
    logic          r_last_data,  w_last_data_next;
    logic          r_done_data,  w_done_data_next;
    logic          r_store,      w_store_next;
    logic [7:0]    r_wait_cnt,   w_wait_cnt_next;
    logic          r_err,        w_err_next;
    logic          r_memreq,     w_memreq_next;
    logic          r_memwe,      w_memwe_next;
    logic [AW-1:0] r_memaddr,    w_memaddr_next;
    logic [DW-1:0] r_memwdata,   w_memwdata_next;
    logic [DW-1:0] r_ifdata,     w_ifdata_next;
    logic [DW-1:0] r_drdata,     w_drdata_next;

    logic          w_grant_data;
    logic          w_grant_if;
    logic [8:0]    w_wait_now;
    logic          w_timeout;
    logic          w_in_busy;

    // Data wins a contest unless it took the previous grant; a lone requester always wins.
    assign w_grant_data = bus.I_dreq && (!bus.I_ifreq || !r_last_data);
    assign w_grant_if   = bus.I_ifreq && !w_grant_data;

    // Cycles waited including the current one; the watchdog fires on the TIMEOUT-th unacked cycle.
    assign w_wait_now = {1'b0, r_wait_cnt} + 9'd1;
    assign w_in_busy  = (r_state == IF_BUSY) || (r_state == D_BUSY);
    assign w_timeout  = w_in_busy && !bus.I_memack && (w_wait_now == 9'(TIMEOUT));

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_state     <= IDLE;
            r_last_data <= 1'b0;
            r_done_data <= 1'b0;
            r_store     <= 1'b0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_memreq    <= 1'b0;
            r_memwe     <= 1'b0;
            r_memaddr   <= '0;
            r_memwdata  <= '0;
            r_ifdata    <= '0;
            r_drdata    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_last_data <= w_last_data_next;
            r_done_data <= w_done_data_next;
            r_store     <= w_store_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_err       <= w_err_next;
            r_memreq    <= w_memreq_next;
            r_memwe     <= w_memwe_next;
            r_memaddr   <= w_memaddr_next;
            r_memwdata  <= w_memwdata_next;
            r_ifdata    <= w_ifdata_next;
            r_drdata    <= w_drdata_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_last_data_next = r_last_data;
        w_done_data_next = r_done_data;
        w_store_next     = r_store;
        w_wait_cnt_next  = r_wait_cnt;
        w_err_next       = r_err;
        w_memreq_next    = r_memreq;
        w_memwe_next     = r_memwe;
        w_memaddr_next   = r_memaddr;
        w_memwdata_next  = r_memwdata;
        w_ifdata_next    = r_ifdata;
        w_drdata_next    = r_drdata;

        unique case (r_state)
            IDLE: begin
                if (w_grant_data) begin
                    w_state_next     = D_BUSY;
                    w_last_data_next = 1'b1;
                    w_done_data_next = 1'b1;
                    w_store_next     = bus.I_dwe;
                    w_wait_cnt_next  = '0;
                    w_err_next       = 1'b0;
                    w_memreq_next    = 1'b1;
                    w_memwe_next     = bus.I_dwe;
                    w_memaddr_next   = bus.I_daddr;
                    w_memwdata_next  = bus.I_dwdata;
                end else if (w_grant_if) begin
                    w_state_next     = IF_BUSY;
                    w_last_data_next = 1'b0;
                    w_done_data_next = 1'b0;
                    w_store_next     = 1'b0;
                    w_wait_cnt_next  = '0;
                    w_err_next       = 1'b0;
                    w_memreq_next    = 1'b1;
                    w_memwe_next     = 1'b0;
                    w_memaddr_next   = bus.I_ifaddr;
                    w_memwdata_next  = '0;
                end
            end

            IF_BUSY, D_BUSY: begin
                if (bus.I_memack) begin
                    // Ack takes priority over a watchdog expiry in the same cycle.
                    w_state_next  = DONE;
                    w_memreq_next = 1'b0;
                    w_memwe_next  = 1'b0;
                    if (r_state == IF_BUSY) begin
                        w_ifdata_next = bus.I_memrdata;
                    end else if (!r_store) begin
                        w_drdata_next = bus.I_memrdata;
                    end
                end else if (w_timeout) begin
                    w_state_next  = DONE;
                    w_memreq_next = 1'b0;
                    w_memwe_next  = 1'b0;
                    w_err_next    = 1'b1;
                    if (r_state == IF_BUSY) begin
                        w_ifdata_next = '0;
                    end else if (!r_store) begin
                        w_drdata_next = '0;
                    end
                end else if (r_wait_cnt != 8'hFF) begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.O_ifdone   = (r_state == DONE) && !r_done_data;
    assign bus.O_ddone    = (r_state == DONE) &&  r_done_data;
    assign bus.O_err      = (r_state == DONE) &&  r_err;
    assign bus.O_busy     = (r_state != IDLE);
    assign bus.O_ifdata   = r_ifdata;
    assign bus.O_drdata   = r_drdata;
    assign bus.O_memreq   = r_memreq;
    assign bus.O_memwe    = r_memwe;
    assign bus.O_memaddr  = r_memaddr;
    assign bus.O_memwdata = r_memwdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers and a memory model feed directed
// transactions; a monitor pops expected completions and compares data, error and latency.
module tb_mem_arbiter;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          n;       // ack in the n-th request cycle; 0 = never ack
        logic [15:0] rdata;
    } plan_t;

    typedef struct {
        logic        is_data;
        logic [15:0] data;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } dreq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;

    plan_t       plan[$];
    exp_t        sb[$];
    logic [15:0] if_q[$];
    dreq_t       d_q[$];
    int          if_raise[$];
    int          d_raise[$];

    logic if_active = 1'b0;
    logic d_active  = 1'b0;
    logic stray_ack = 1'b0;
    int   last_req_len = 0;

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
        .I_clk   (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue_if(input logic [15:0] addr, input int n, input logic [15:0] rdata,
                            input logic [15:0] exp_data, input logic exp_err, input int lat);
        plan.push_back('{addr, 1'b0, 16'h0000, n, rdata});
        sb.push_back('{1'b0, exp_data, exp_err, lat});
        if_q.push_back(addr);
    endtask

    task automatic issue_d(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                           input int n, input logic [15:0] rdata, input logic expect_done,
                           input logic [15:0] exp_data, input logic exp_err, input int lat);
        plan.push_back('{addr, we, we ? wdata : wdata, n, rdata});
        if (expect_done) sb.push_back('{1'b1, exp_data, exp_err, lat});
        d_q.push_back('{addr, we, wdata});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && if_q.size() == 0 && d_q.size() == 0 &&
                !if_active && !d_active && !bus.O_busy) begin
                chk("plan_consumed", 16'(plan.size()), 16'd0);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    // Fetch requester: holds the request until its done cycle ends, then takes the next one.
    initial begin
        logic done_seen;
        bus.I_ifreq  = 1'b0;
        bus.I_ifaddr = '0;
        forever begin
            @(negedge clk);
            done_seen = bus.O_ifdone;
            @(posedge clk);
            #1;
            if (rst) begin
                bus.I_ifreq = 1'b0;
                if_active   = 1'b0;
                if_raise.delete();
            end else begin
                if (if_active && done_seen) begin
                    bus.I_ifreq = 1'b0;
                    if_active   = 1'b0;
                end
                if (!if_active && if_q.size() > 0) begin
                    bus.I_ifaddr = if_q.pop_front();
                    bus.I_ifreq  = 1'b1;
                    if_active    = 1'b1;
                    if_raise.push_back(cyc);
                end
            end
        end
    end

    // Load/store requester.
    initial begin
        logic  done_seen;
        dreq_t r;
        bus.I_dreq   = 1'b0;
        bus.I_dwe    = 1'b0;
        bus.I_daddr  = '0;
        bus.I_dwdata = '0;
        forever begin
            @(negedge clk);
            done_seen = bus.O_ddone;
            @(posedge clk);
            #1;
            if (rst) begin
                bus.I_dreq = 1'b0;
                d_active   = 1'b0;
                d_raise.delete();
            end else begin
                if (d_active && done_seen) begin
                    bus.I_dreq = 1'b0;
                    d_active   = 1'b0;
                end
                if (!d_active && d_q.size() > 0) begin
                    r            = d_q.pop_front();
                    bus.I_daddr  = r.addr;
                    bus.I_dwe    = r.we;
                    bus.I_dwdata = r.wdata;
                    bus.I_dreq   = 1'b1;
                    d_active     = 1'b1;
                    d_raise.push_back(cyc);
                end
            end
        end
    end

    // Memory model: checks each new transaction against the plan and acks as planned.
    initial begin
        plan_t cur;
        logic  serving;
        int    req_len;
        serving        = 1'b0;
        req_len        = 0;
        cur            = '{16'h0, 1'b0, 16'h0, 0, 16'h0};
        bus.I_memack   = 1'b0;
        bus.I_memrdata = '0;
        forever begin
            @(negedge clk);
            bus.I_memack = 1'b0;
            if (stray_ack) begin
                bus.I_memack   = 1'b1;
                bus.I_memrdata = 16'hDEAD;
                stray_ack      = 1'b0;
            end
            if (serving && !bus.O_memreq) begin
                last_req_len = req_len;
                serving      = 1'b0;
            end
            if (bus.O_memreq && !serving) begin
                if (plan.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_memreq: got addr %h expected no request", bus.O_memaddr);
                    cur = '{bus.O_memaddr, bus.O_memwe, bus.O_memwdata, 1, 16'h0};
                end else begin
                    cur = plan.pop_front();
                    chk("memaddr",  bus.O_memaddr,        cur.addr);
                    chk("memwe",    16'(bus.O_memwe),     16'(cur.we));
                    chk("memwdata", bus.O_memwdata,       cur.wdata);
                end
                serving = 1'b1;
                req_len = 0;
            end
            if (serving && bus.O_memreq) begin
                req_len++;
                if (cur.n != 0 && req_len == cur.n) begin
                    bus.I_memack   = 1'b1;
                    bus.I_memrdata = cur.rdata;
                end
            end
        end
    end

    // Completion monitor: one line per finished transaction.
    initial begin
        exp_t        e;
        int          lat;
        logic [15:0] got;
        forever begin
            @(negedge clk);
            if (!rst && (bus.O_ifdone || bus.O_ddone)) begin
                done_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got ifdone=%0b ddone=%0b expected none",
                             bus.O_ifdone, bus.O_ddone);
                end else begin
                    e = sb.pop_front();
                    chk("done_data_ch", 16'(bus.O_ddone),  16'(e.is_data));
                    chk("done_if_ch",   16'(bus.O_ifdone), 16'(!e.is_data));
                    if (bus.O_ddone) begin
                        got = bus.O_drdata;
                        lat = (d_raise.size() > 0) ? cyc - d_raise.pop_front() : -1;
                    end else begin
                        got = bus.O_ifdata;
                        lat = (if_raise.size() > 0) ? cyc - if_raise.pop_front() : -1;
                    end
                    chk("done_rdata",   got,               e.data);
                    chk("done_err",     16'(bus.O_err),    16'(e.err));
                    chk("done_latency", 16'(lat),          16'(e.lat));
                    $display("txn cyc=%0d %s data=%h err=%0b lat=%0d",
                             cyc, bus.O_ddone ? "data " : "fetch", got, bus.O_err, lat);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int snap;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("rst_memreq",  16'(bus.O_memreq), 16'd0);
        chk("rst_memwe",   16'(bus.O_memwe),  16'd0);
        chk("rst_busy",    16'(bus.O_busy),   16'd0);
        chk("rst_err",     16'(bus.O_err),    16'd0);
        chk("rst_memaddr", bus.O_memaddr,     16'h0000);
        chk("rst_ifdata",  bus.O_ifdata,      16'h0000);
        chk("rst_drdata",  bus.O_drdata,      16'h0000);

        // Single fetch, ack in first request cycle.
        issue_if(16'h0040, 1, 16'hA5C3, 16'hA5C3, 1'b0, 2);
        wait_idle();

        // Store with ack in its 3rd cycle; read register keeps 0. Then load back.
        issue_d(16'h0100, 1'b1, 16'h1234, 3, 16'hBAD0, 1'b1, 16'h0000, 1'b0, 4);
        wait_idle();
        issue_d(16'h0100, 1'b0, 16'h0000, 1, 16'h1234, 1'b1, 16'h1234, 1'b0, 2);
        wait_idle();
        issue_d(16'h0200, 1'b1, 16'hFFFF, 2, 16'hBAD1, 1'b1, 16'h1234, 1'b0, 3);
        wait_idle();

        // Contention straight after reset: data, fetch, data, fetch.
        pulse_reset();
        issue_d (16'h0300, 1'b0, 16'h0000, 1, 16'h1111, 1'b1, 16'h1111, 1'b0, 2);
        issue_if(16'h0044, 2, 16'h2222, 16'h2222, 1'b0, 6);
        issue_d (16'h0304, 1'b1, 16'h5555, 1, 16'hBAD2, 1'b1, 16'h1111, 1'b0, 6);
        issue_if(16'h0048, 1, 16'h3333, 16'h3333, 1'b0, 5);
        wait_idle();

        // Timeout on a load, then a normal load.
        issue_d(16'h0400, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16);
        wait_idle();
        chk("timeout_req_len", 16'(last_req_len), 16'd15);
        issue_d(16'h0402, 1'b0, 16'h0000, 1, 16'h7777, 1'b1, 16'h7777, 1'b0, 2);
        wait_idle();

        // Ack on the last permitted wait cycle.
        issue_if(16'h0050, 15, 16'h9999, 16'h9999, 1'b0, 16);
        wait_idle();
        chk("lastack_req_len", 16'(last_req_len), 16'd15);

        // Asynchronous reset mid-access, then a stray ack while idle.
        snap = done_count;
        issue_d(16'h0500, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
        for (int i = 0; i < 20 && !bus.O_memreq; i++) @(negedge clk);
        chk("async_req_seen", 16'(bus.O_memreq), 16'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_memreq", 16'(bus.O_memreq), 16'd0);
        chk("async_busy",   16'(bus.O_busy),   16'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_busy",   16'(bus.O_busy),   16'd0);
        chk("stray_memreq", 16'(bus.O_memreq), 16'd0);
        chk("stray_drdata", bus.O_drdata,      16'h0000);
        chk("stray_ifdata", bus.O_ifdata,      16'h0000);
        chk("no_done_after_reset", 16'(done_count - snap), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
